// File: rtl/avalon_bus_matrix_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : avalon_bus_matrix_arbiter
// Description : Three-master round-robin arbiter onto one Avalon slave port.
//               Optional waitrequest watchdog: define AVALON_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module avalon_bus_matrix_arbiter #(
    parameter int          MstCnt     = 3,
    parameter logic [15:0] TimeoutCyc = 16'd1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Req0_i,
    input  logic         Req1_i,
    input  logic         Req2_i,
    input  logic [63:0]  Addr0_i,
    input  logic [511:0] WrData0_i,
    input  logic [63:0]  ByteEn0_i,
    input  logic         RdEn0_i,
    input  logic         WrEn0_i,
    input  logic [63:0]  Addr1_i,
    input  logic [511:0] WrData1_i,
    input  logic [63:0]  ByteEn1_i,
    input  logic         RdEn1_i,
    input  logic         WrEn1_i,
    input  logic [63:0]  Addr2_i,
    input  logic [511:0] WrData2_i,
    input  logic [63:0]  ByteEn2_i,
    input  logic         RdEn2_i,
    input  logic         WrEn2_i,
    output logic [63:0]  Addr_o,
    output logic [511:0] WrData_o,
    output logic [63:0]  ByteEn_o,
    output logic         RdEn_o,
    output logic         WrEn_o,
    input  logic         WaitReq_i,
    output logic [2:0]   PortSel_o,
    output logic         Timeout_o
);

    localparam logic [1:0] c_LAST_INIT = 2'(MstCnt - 1);
    localparam logic [2:0] c_NO_GRANT  = 3'h7;

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t     r_state;
    logic [1:0] r_grant;
    logic [1:0] r_last;
    logic [2:0] r_port_sel;
    logic [2:0] w_req;
    logic [1:0] w_pick;
    logic       w_gnt_req;

    assign w_req     = {Req2_i, Req1_i, Req0_i};
    assign w_gnt_req = w_req[r_grant];
    assign PortSel_o = r_port_sel;

    // Search order last+1, last+2, last (mod 3); only used when some req is high.
    function automatic logic [1:0] f_rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] c1;
        logic [1:0] c2;
        c1 = (last == 2'd2) ? 2'd0 : last + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        if (req[c1])
            return c1;
        else if (req[c2])
            return c2;
        else
            return last;
    endfunction

    assign w_pick = f_rr_pick(w_req, r_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant    <= 2'd0;
            r_last     <= c_LAST_INIT;
            r_port_sel <= c_NO_GRANT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_grant    <= w_pick;
                        r_port_sel <= {1'b0, w_pick};
                        r_state    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Completion or an abandoned request both release the bus.
                    if (!w_gnt_req || !WaitReq_i) begin
                        r_last     <= r_grant;
                        r_port_sel <= c_NO_GRANT;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        Addr_o   = '0;
        WrData_o = '0;
        ByteEn_o = '0;
        RdEn_o   = 1'b0;
        WrEn_o   = 1'b0;
        if (r_state == S_BUSY) begin
            case (r_grant)
                2'd0: begin
                    Addr_o = Addr0_i; WrData_o = WrData0_i; ByteEn_o = ByteEn0_i;
                    RdEn_o = RdEn0_i; WrEn_o = WrEn0_i;
                end
                2'd1: begin
                    Addr_o = Addr1_i; WrData_o = WrData1_i; ByteEn_o = ByteEn1_i;
                    RdEn_o = RdEn1_i; WrEn_o = WrEn1_i;
                end
                2'd2: begin
                    Addr_o = Addr2_i; WrData_o = WrData2_i; ByteEn_o = ByteEn2_i;
                    RdEn_o = RdEn2_i; WrEn_o = WrEn2_i;
                end
                default: ;
            endcase
        end
    end

`ifdef AVALON_ARB_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_timeout;

    // Flag is sticky until reset; the grant itself is left alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= 16'd0;
            r_timeout  <= 1'b0;
        end else if (r_state == S_BUSY && WaitReq_i) begin
            if (r_wait_cnt != 16'hFFFF)
                r_wait_cnt <= r_wait_cnt + 16'd1;
            if (r_wait_cnt + 16'd1 == TimeoutCyc)
                r_timeout <= 1'b1;
        end else begin
            r_wait_cnt <= 16'd0;
        end
    end

    assign Timeout_o = r_timeout;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TimeoutCyc;
    assign Timeout_o            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/avalon_bus_matrix_arbiter.md
AVALON_BUS_MATRIX_ARBITER -- requirements
Module: avalon_bus_matrix_arbiter

Interface
REQ-001 SHALL have parameter MstCnt, default 3, meaning the number of master ports; only the value 3 is supported.
REQ-002 SHALL have parameter TimeoutCyc, default 16'd1024, meaning the consecutive slave-wait cycles before a timeout is flagged.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports Req0_i, Req1_i, Req2_i, input, 1 bit each: per-master request from the master-side decoder.
REQ-006 SHALL have ports AddrN_i (input, 64 bits), WrDataN_i (input, 512 bits), ByteEnN_i (input, 64 bits), RdEnN_i and WrEnN_i (input, 1 bit each), for N = 0..2.
REQ-007 SHALL have ports Addr_o (output, 64), WrData_o (output, 512), ByteEn_o (output, 64), RdEn_o (output, 1) and WrEn_o (output, 1): the slave-side command.
REQ-008 SHALL have port WaitReq_i, input, 1 bit: slave waitrequest.
REQ-009 SHALL have port PortSel_o, output, 3 bits: granted master ID (0..2); 3'h7 means no grant.
REQ-010 SHALL have port Timeout_o, output, 1 bit: sticky watchdog flag.

Function
REQ-011 SHALL implement FSM states IDLE and BUSY; PortSel_o SHALL be driven from a registered grant index, never combinationally from Req inputs.
REQ-012 In IDLE, with any Req high, the arbiter SHALL register a grant at the next clk edge and enter BUSY, so PortSel_o is valid one cycle after the request.
REQ-013 Arbitration SHALL be round-robin: search order Last+1, Last+2, Last (mod 3), where Last is the previously granted index.
REQ-014 In BUSY, the granted master's Addr, WrData, ByteEn, RdEn and WrEn SHALL pass combinationally to the slave outputs.
REQ-015 In IDLE, the slave outputs SHALL be all zeros.
REQ-016 A transaction SHALL complete in a cycle where the granted Req is high and WaitReq_i is low; at that edge the FSM SHALL return to IDLE and update Last.
REQ-017 This produces one mandatory IDLE bubble cycle between grants.
REQ-018 If the granted Req drops without a completion, the FSM SHALL go to IDLE at the next edge, and Last SHALL be updated.
REQ-019 Requests arriving while BUSY SHALL be held off; requesters see PortSel_o != own ID.
REQ-020 Requests are never queued; a request is considered only while its Req is high.
REQ-021 Back-to-back traffic: a master whose transaction completes and which re-requests immediately SHALL be served only after every other requester pending in that IDLE cycle.

Reset
REQ-022 While rst is high, the FSM SHALL be IDLE, PortSel_o SHALL be 3'h7, Last SHALL be 2 (so master 0 wins first), the wait counter SHALL be 0, Timeout_o SHALL be 0, and all slave outputs SHALL be 0.
REQ-023 Assertion of rst mid-transaction SHALL abandon the grant immediately (asynchronously); no completion is signalled.

Configuration
REQ-024 With macro AVALON_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles in BUSY with WaitReq_i high and SHALL clear on completion or when entering IDLE.
REQ-025 When the counter reaches TimeoutCyc, Timeout_o SHALL set and stay set until rst; the grant SHALL NOT be revoked.
REQ-026 With AVALON_ARB_TIMEOUT_EN undefined, the counter SHALL be absent and Timeout_o SHALL be tied to 0.

Verification
REQ-027 After reset, Req0..2 all high with WaitReq_i=0 -> grants in order 0, 1, 2, 0, each lasting 1 cycle with 1 IDLE cycle between; PortSel_o sequence 0,7,1,7,2,7,0.
REQ-028 Req1 only, RdEn1=1, Addr1=64'h200, WaitReq_i high for 3 cycles -> PortSel_o=1 for 4 cycles, Addr_o=64'h200, RdEn_o=1, then PortSel_o=7.
REQ-029 Master 0 granted, Req0 dropped without completion -> PortSel_o=7 next cycle; Req2 then pending -> PortSel_o=2 one cycle later.
REQ-030 rst pulsed while BUSY with WrEn_o=1 -> WrEn_o=0 and PortSel_o=7 immediately; the first grant after release goes to master 0.
REQ-031 With AVALON_ARB_TIMEOUT_EN defined and TimeoutCyc=8, WaitReq_i held high -> Timeout_o rises after 8 wait cycles, stays 1 after completion, and clears only on rst; without the macro, Timeout_o stays 0 throughout.
